// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive FIFO: default sizes, the trigger codes
// and the layout of a stored entry.
package uart_pkg;

    localparam int FIFO_DEPTH = 16;
    localparam int CHAR_W     = 8;
    localparam int FLAG_W     = 3;

    typedef enum logic [1:0] {
        TRIG_1  = 2'b00,
        TRIG_4  = 2'b01,
        TRIG_8  = 2'b10,
        TRIG_14 = 2'b11
    } trig_e;

    // An entry is stored as {flags, data}, with bi as the most significant bit.
    typedef struct packed {
        logic bi;
        logic fe;
        logic pe;
    } rx_err_t;

    function automatic logic [4:0] trig_level(input trig_e code);
        case (code)
            TRIG_1:  return 5'd1;
            TRIG_4:  return 5'd4;
            TRIG_8:  return 5'd8;
            TRIG_14: return 5'd14;
            default: return 5'd1;
        endcase
    endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// Register array with one write port and one asynchronous read port.
// The contents are not reset; the pointer logic in the parent decides what is valid.
module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH,
    parameter int W     = CHAR_W + FLAG_W,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [DEPTH-1:0][W-1:0] mem;

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// 16550-style receive FIFO: show-ahead read port, per-entry error flags,
// sticky overrun, trigger-level compare and single-entry 16450 mode.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH,
    parameter int DW    = CHAR_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [DW-1:0]            wr_data,
    input  logic                     wr_pe,
    input  logic                     wr_fe,
    input  logic                     wr_bi,
    input  logic                     rd_en,
    input  logic                     fifo_en,
    input  logic                     fifo_clr,
    input  logic [1:0]               rx_trig,
    input  logic                     lsr_rd,
    output logic [DW-1:0]            rd_data,
    output logic                     pe,
    output logic                     fe,
    output logic                     bi,
    output logic                     dr,
    output logic                     below_level,
    output logic                     oe,
    output logic                     fifo_err,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = DW + FLAG_W;

    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] cnt, err_cnt, cap, trig;
    logic          fifo_en_q, clr, full, do_push, do_pop, ovr, push_err, pop_err;
    logic [EW-1:0] wr_ent, rd_ent, head;
    rx_err_t       wr_flags, hd_flags;

    assign wr_flags = {wr_bi, wr_fe, wr_pe};
    assign wr_ent   = {wr_flags, wr_data};

    // Any change of fifo_en flushes the FIFO, same as an explicit clear.
    assign clr     = fifo_clr | (fifo_en ^ fifo_en_q);
    assign cap     = fifo_en ? CW'(DEPTH) : CW'(1);
    assign full    = (cnt >= cap);
    assign do_pop  = !clr && rd_en && (cnt != '0);
    assign do_push = !clr && wr_en && (!full || do_pop);
    assign ovr     = !clr && wr_en && full && !do_pop;

    assign push_err = do_push && (|wr_flags);
    assign pop_err  = do_pop && (|hd_flags);

    uart_fifo_mem #(.DEPTH(DEPTH), .W(EW), .AW(AW)) u_mem (
        .clk   (clk),
        .we    (do_push),
        .waddr (wr_ptr),
        .wdata (wr_ent),
        .raddr (rd_ptr),
        .rdata (rd_ent)
    );

    assign head = (cnt != '0) ? rd_ent : '0;
    assign {hd_flags, rd_data} = head;
    assign bi = hd_flags.bi;
    assign fe = hd_flags.fe;
    assign pe = hd_flags.pe;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cnt       <= '0;
            err_cnt   <= '0;
            fifo_en_q <= 1'b0;
        end else begin
            fifo_en_q <= fifo_en;
            if (clr) begin
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                cnt     <= '0;
                err_cnt <= '0;
            end else begin
                if (do_push) wr_ptr <= wr_ptr + 1'b1;
                if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
                case ({do_push, do_pop})
                    2'b10:   cnt <= cnt + 1'b1;
                    2'b01:   cnt <= cnt - 1'b1;
                    default: cnt <= cnt;
                endcase
                case ({push_err, pop_err})
                    2'b10:   err_cnt <= err_cnt + 1'b1;
                    2'b01:   err_cnt <= err_cnt - 1'b1;
                    default: err_cnt <= err_cnt;
                endcase
            end
        end
    end

    // Overrun is sticky; a new overrun in the same cycle as an LSR read wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      oe <= 1'b0;
        else if (ovr)    oe <= 1'b1;
        else if (lsr_rd) oe <= 1'b0;
    end

    assign trig        = fifo_en ? CW'(trig_level(trig_e'(rx_trig))) : CW'(1);
    assign below_level = (cnt < trig);
    assign dr          = (cnt != '0);
    assign fifo_err    = (err_cnt != '0);
    assign count       = cnt;

endmodule
